// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM generator.
package pwm_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int MIN_PERIOD = 2;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

endpackage

// File: rtl/pwm_multi_channel_gen_if.sv
// Control inputs and PWM outputs of the multi-channel generator.
interface pwm_multi_channel_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              ena;
  logic              btn_inc;
  logic              btn_dec;
  logic [SEL_W-1:0]  ch_sel;
  logic [CNT_W-1:0]  period_in;
  logic              mode_in;
  logic [NUM_CH-1:0] pwm_out;
  logic              boundary;

  modport master (
    output ena, btn_inc, btn_dec, ch_sel, period_in, mode_in,
    input  pwm_out, boundary
  );

  modport slave (
    input  ena, btn_inc, btn_dec, ch_sel, period_in, mode_in,
    output pwm_out, boundary
  );
endinterface

// File: rtl/pwm_btn_debounce.sv
// Two-flop button sampler; emits a one-cycle pulse on a sampled rising edge.
module pwm_btn_debounce (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic btn,
  output logic press
);
  logic s1, s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (en) begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  assign press = s1 & ~s2 & en;
endmodule

// File: rtl/pwm_multi_channel_gen.sv
// NUM_CH PWM channels sharing one period counter; duty/period/mode shadowed to the period boundary.
// state    | meaning
// DIR_UP   | counting 0..P-1 (edge mode never leaves this state)
// DIR_DOWN | centre mode, counting P-2..1 back toward the boundary
module pwm_multi_channel_gen
  import pwm_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int PERIOD_RST = 10,
  parameter int DUTY_INIT  = 5,
  parameter int STEP       = 1,
  parameter int DEB_DIV    = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  pwm_multi_channel_gen_if.slave bus
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PRE_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [CNT_W:0]   STEP_X = (CNT_W+1)'(STEP);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

  logic [PRE_W-1:0]  prescaler;
  logic              tick, deb_en;
  logic              inc_pulse, dec_pulse, press_inc, press_dec, sel_ok;
  logic [CNT_W-1:0]  cnt, cnt_nxt, act_period, new_period;
  pwm_dir_e          dir, dir_nxt;
  pwm_mode_e         act_mode;
  logic              at_boundary;
  logic [NUM_CH-1:0] pwm_cmp, pwm_q;
  logic              bnd_q;

  assign tick   = (prescaler == PRE_W'(DEB_DIV - 1));
  assign deb_en = tick & bus.ena;

  always_ff @(posedge clk) begin
    if (!rst_n)       prescaler <= '0;
    else if (bus.ena) prescaler <= tick ? '0 : prescaler + 1'b1;
  end

  pwm_btn_debounce u_deb_inc (
    .clk(clk), .rst_n(rst_n), .en(deb_en), .btn(bus.btn_inc), .press(inc_pulse)
  );

  pwm_btn_debounce u_deb_dec (
    .clk(clk), .rst_n(rst_n), .en(deb_en), .btn(bus.btn_dec), .press(dec_pulse)
  );

  // Opposing presses on the same tick cancel out.
  assign sel_ok    = (int'(bus.ch_sel) < NUM_CH);
  assign press_inc = inc_pulse & ~dec_pulse & sel_ok;
  assign press_dec = dec_pulse & ~inc_pulse & sel_ok;

  assign at_boundary = (cnt == '0) && (dir == DIR_UP);
  assign new_period  = (bus.period_in < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : bus.period_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else if (bus.ena) begin
      cnt <= cnt_nxt;
      dir <= dir_nxt;
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    unique case (dir)
      DIR_UP: begin
        if (cnt == act_period - 1'b1) begin
          // With P=2 the down leg is empty, so centre mode wraps like edge mode.
          if (act_mode == PWM_CENTER && act_period > CNT_W'(MIN_PERIOD)) begin
            cnt_nxt = cnt - 1'b1;
            dir_nxt = DIR_DOWN;
          end else begin
            cnt_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DIR_DOWN: begin
        if (cnt == CNT_W'(1)) begin
          cnt_nxt = '0;
          dir_nxt = DIR_UP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_period <= CNT_W'(PERIOD_RST);
      act_mode   <= PWM_EDGE;
    end else if (bus.ena && at_boundary) begin
      act_period <= new_period;
      act_mode   <= pwm_mode_e'(bus.mode_in);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] target, act_duty, duty_clamp, duty_eff, inc_val, dec_val;
    logic [CNT_W:0]   inc_sum;
    logic             sel_hit;

    assign sel_hit    = sel_ok && (bus.ch_sel == SEL_W'(i));
    assign inc_sum    = {1'b0, target} + STEP_X;
    assign inc_val    = (inc_sum > {1'b0, act_period}) ? act_period : inc_sum[CNT_W-1:0];
    assign dec_val    = ({1'b0, target} >= STEP_X) ? (target - STEP_C) : '0;
    assign duty_clamp = (target > new_period) ? new_period : target;
    // The first cycle of a new period already compares against the new duty.
    assign duty_eff   = at_boundary ? duty_clamp : act_duty;
    assign pwm_cmp[i] = (cnt < duty_eff);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        target   <= CNT_W'(DUTY_INIT);
        act_duty <= CNT_W'(DUTY_INIT);
      end else if (bus.ena) begin
        if (sel_hit && press_inc)      target <= inc_val;
        else if (sel_hit && press_dec) target <= dec_val;
        else if (at_boundary)          target <= duty_clamp;
        if (at_boundary) act_duty <= duty_clamp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_q <= '0;
      bnd_q <= 1'b0;
    end else if (bus.ena) begin
      pwm_q <= pwm_cmp;
      bnd_q <= at_boundary;
    end else begin
      pwm_q <= '0;
      bnd_q <= 1'b0;
    end
  end

  assign bus.pwm_out  = pwm_q;
  assign bus.boundary = bnd_q;
endmodule

// File: doc/pwm_multi_channel_gen.md
Name: pwm_multi_channel_gen

Overview:
Multi-channel successor to the single-channel 10-step PWM generator, and the next generation of that block.
- Generates NUM_CH PWM outputs from one shared period counter with a runtime-programmable period.
- Selectable edge-aligned or centre-aligned mode.
- Per-channel duty is adjusted by debounced inc/dec buttons steered by a channel select.
- Duty, period and mode updates are shadowed, taking effect only at the period boundary, so outputs are glitch-free.

Parameters:
NUM_CH, 4, number of PWM channels (1..16)
CNT_W, 8, width of period counter, period and duty registers
PERIOD_RST, 10, active period after reset (2..2^CNT_W-1)
DUTY_INIT, 5, reset duty of every channel (<= PERIOD_RST)
STEP, 1, duty increment/decrement per debounced press
DEB_DIV, 4, debounce sample-tick divider in clk cycles (>=1; FPGA builds override to ~12500000)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ena  in  1  block enable; low freezes the block and drives outputs low
btn_inc  in  1  raw increase-duty button, asynchronous
btn_dec  in  1  raw decrease-duty button, asynchronous
ch_sel  in  max(1,$clog2(NUM_CH))  channel targeted by button presses
period_in  in  CNT_W  requested period in counter steps
mode_in  in  1  0 = edge-aligned, 1 = centre-aligned
pwm_out  out  NUM_CH  registered PWM outputs, bit i = channel i
boundary  out  1  one-cycle pulse at each period start (registered)

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - pwm_out=0, boundary=0, cnt=0, dir=up, prescaler=0, debounce flops=0.
  - Active period = PERIOD_RST, active mode = 0.
  - All target and active duties = DUTY_INIT.
  - Reset mid-period aborts the period immediately.
- ena=0:
  - prescaler, cnt and dir hold; button sampling is suspended.
  - pwm_out and boundary forced 0 on the next edge.
  - On return to ena=1, the block resumes from the held state.
- Debounce:
  - Prescaler counts 0..DEB_DIV-1; tick=1 when prescaler==DEB_DIV-1.
  - On tick, each button shifts through two flops s1->s2.
  - A press pulse = s1 & ~s2 & tick.
  - Both inc and dec pulses on the same tick -> no duty change.
- Duty targets:
  - A press updates target[ch_sel] only.
  - inc: target = min(target+STEP, active_period).
  - dec: target = max(target-STEP, 0).
  - Arithmetic in CNT_W+1 bits, no wrap.
  - ch_sel >= NUM_CH -> press ignored.
- Counter, edge mode (mode 0): cnt runs 0..P-1 and wraps; period = P cycles.
- Counter, centre mode (mode 1): cnt runs up 0..P-1, then down P-2..1; period = 2P-2 cycles.
- Boundary:
  - Occurs in the cycle where cnt==0 (and dir=up).
  - At boundary: active_period <= max(period_in, 2); active_mode <= mode_in; active_duty[i] <= min(target[i], new period).
  - Targets above the new period are also clamped in the same cycle.
  - boundary output pulses one cycle later, aligned with pwm_out.
- Output: pwm_out[i] registered = (cnt < active_duty[i]), one-cycle latency from cnt.
  - duty 0 -> constantly low.
  - duty = P -> constantly high.
- A press in the boundary cycle updates the target; the new value is visible at the following boundary.

Decomposition:
- Shared package pwm_pkg holds:
  - typedefs cnt_t (logic [CNT_W-1:0]) and the mode enum (PWM_EDGE, PWM_CENTER);
  - constants for the minimum period (2).
- One natural sub-module: pwm_btn_debounce. It takes clk, rst_n, en=tick&ena and a raw button, and produces the press pulse. Instantiate it twice.
- Counter, shadow registers and channel comparators stay in the top module; the comparators use a generate loop.

Test Plan:
- Reset defaults: NUM_CH=4, DEB_DIV=1; ena=1, no presses -> every channel high 5 of 10 cycles, boundary every 10 cycles.
- Channel-targeted press: ch_sel=2, one btn_inc press -> only pwm_out[2] goes to 6/10, starting at the next boundary; other channels stay 5/10.
- Saturation: 7 btn_inc presses on ch0 -> duty stops at 10 (constant high). Then 12 btn_dec presses -> duty 0 (constant low), no wrap.
- Period change: period_in=20 applied mid-period -> current period completes at 10 cycles, the next lasts 20. period_in=1 -> clamped to 2.
- Centre mode: mode_in=1, P=10, duty 4 -> 18-cycle period with high pulse centred on cnt=0 (cnt 0..3 up, 3..1 down). Simultaneous inc+dec -> no change.
- ena/reset: ena=0 for 7 cycles mid-period -> outputs 0, period resumes where it stopped. rst_n=0 mid-period -> all defaults restored next cycle.
